// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the two requesters, the dmem_arbiter and the data memory port.
// slave  : seen from the arbiter (takes requests, drives the memory).
// master : seen from the environment (requesters plus memory).
interface dmem_arbiter_if;

  // Port 0: CPU load/store unit
  logic        req0_valid;
  logic        req0_ready;
  logic [31:0] req0_addr;
  logic [31:0] req0_wdata;
  logic        req0_we;
  logic [3:0]  req0_sign_mask;
  logic        resp0_valid;
  logic [31:0] resp0_rdata;
  logic        resp0_err;

  // Port 1: auxiliary master (debug loader / DMA)
  logic        req1_valid;
  logic        req1_ready;
  logic [31:0] req1_addr;
  logic [31:0] req1_wdata;
  logic        req1_we;
  logic [3:0]  req1_sign_mask;
  logic        resp1_valid;
  logic [31:0] resp1_rdata;
  logic        resp1_err;

  // Single data memory port
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic        mem_memwrite;
  logic        mem_memread;
  logic [3:0]  mem_sign_mask;
  logic [31:0] mem_read_data;
  logic        mem_clk_stall;

  modport slave (
    input  req0_valid, req0_addr, req0_wdata, req0_we, req0_sign_mask,
    input  req1_valid, req1_addr, req1_wdata, req1_we, req1_sign_mask,
    output req0_ready, req1_ready,
    output resp0_valid, resp0_rdata, resp0_err,
    output resp1_valid, resp1_rdata, resp1_err,
    output mem_addr, mem_write_data, mem_memwrite, mem_memread, mem_sign_mask,
    input  mem_read_data, mem_clk_stall
  );

  modport master (
    output req0_valid, req0_addr, req0_wdata, req0_we, req0_sign_mask,
    output req1_valid, req1_addr, req1_wdata, req1_we, req1_sign_mask,
    input  req0_ready, req1_ready,
    input  resp0_valid, resp0_rdata, resp0_err,
    input  resp1_valid, resp1_rdata, resp1_err,
    input  mem_addr, mem_write_data, mem_memwrite, mem_memread, mem_sign_mask,
    output mem_read_data, mem_clk_stall
  );

endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer in front of the single data memory port.
// One transaction at a time: IDLE (grant) -> ISSUE (1-cycle strobe) -> WAIT (track the
// memory busy window, or time out) -> RESP (1-cycle response on the granted port).
// Optional build macro DMEM_ARB_RR_EN: round-robin on ties; otherwise port 0 always
// wins a tie.
// TIMEOUT_CYCLES must be < 2**CNT_W.
module dmem_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 15,
  parameter int unsigned CNT_W          = 4
) (
  input logic           clk,
  input logic           reset_n,
  dmem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StResp
  } state_e;

  state_e           state_q, state_d;

  logic             grant0, grant1;
  logic             ready0, ready1;
  logic             idle_free;
  logic             accept;
  logic             accept_idx;

  // Request buffers, loaded on accept
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic             we_q;
  logic [3:0]       mask_q;
  logic             gnt_q;

  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             seen_busy_q, seen_busy_d;
  logic             done;
  logic             timeout;
  logic [31:0]      rdata_q, rdata_d;
  logic             err_q, err_d;

`ifdef DMEM_ARB_RR_EN
  logic last_grant_q;

  // Round-robin tie-break: the port not granted last time wins.
  always_comb begin
    grant0 = bus.req0_valid & (~bus.req1_valid | last_grant_q);
    grant1 = bus.req1_valid & ~grant0;
  end

  // Remember the most recently accepted port; reset value lets port 0 win the first tie.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q <= 1'b1;
    end else if (accept) begin
      last_grant_q <= accept_idx;
    end
  end
`else
  // Fixed priority: port 0 always wins a tie.
  always_comb begin
    grant0 = bus.req0_valid;
    grant1 = bus.req1_valid & ~bus.req0_valid;
  end
`endif

  // Grants are only offered in IDLE and only once the memory has finished any access
  // that may still be in flight (e.g. after a mid-transaction reset).
  assign idle_free  = (state_q == StIdle) & ~bus.mem_clk_stall;
  assign ready0     = idle_free & grant0;
  assign ready1     = idle_free & grant1;
  assign accept     = ready0 | ready1;
  assign accept_idx = ready1;

  assign bus.req0_ready = ready0;
  assign bus.req1_ready = ready1;

  // Latch the winning request's fields on accept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      mask_q  <= '0;
      gnt_q   <= 1'b0;
    end else if (accept) begin
      addr_q  <= accept_idx ? bus.req1_addr      : bus.req0_addr;
      wdata_q <= accept_idx ? bus.req1_wdata     : bus.req0_wdata;
      we_q    <= accept_idx ? bus.req1_we        : bus.req0_we;
      mask_q  <= accept_idx ? bus.req1_sign_mask : bus.req0_sign_mask;
      gnt_q   <= accept_idx;
    end
  end

  assign cnt_inc = cnt_q + CNT_W'(1);
  // Completion needs a busy phase first, so an idle memory cannot fake a finish.
  assign done    = seen_busy_q & ~bus.mem_clk_stall;
  assign timeout = (cnt_inc == CNT_W'(TIMEOUT_CYCLES));

  // Next-state and WAIT/RESP bookkeeping.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    seen_busy_d = seen_busy_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StIssue;
        end
      end
      StIssue: begin
        state_d = StWait;
      end
      StWait: begin
        cnt_d = cnt_inc;
        if (bus.mem_clk_stall) begin
          seen_busy_d = 1'b1;
        end
        // Completion wins over a timeout landing in the same cycle.
        if (done) begin
          rdata_d = we_q ? 32'h0 : bus.mem_read_data;
          err_d   = 1'b0;
          state_d = StResp;
        end else if (timeout) begin
          rdata_d = 32'h0;
          err_d   = 1'b1;
          state_d = StResp;
        end
      end
      StResp: begin
        cnt_d       = '0;
        seen_busy_d = 1'b0;
        rdata_d     = 32'h0;
        err_d       = 1'b0;
        state_d     = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State, wait counter and captured response.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      seen_busy_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      seen_busy_q <= seen_busy_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  // Memory port: address/data always come from the buffers, strobes only in ISSUE.
  assign bus.mem_addr       = addr_q;
  assign bus.mem_write_data = wdata_q;
  assign bus.mem_sign_mask  = mask_q;
  assign bus.mem_memread    = (state_q == StIssue) & ~we_q;
  assign bus.mem_memwrite   = (state_q == StIssue) & we_q;

  // Response: rdata/err are only non-zero during RESP, steered to the granted port.
  assign bus.resp0_valid = (state_q == StResp) & ~gnt_q;
  assign bus.resp1_valid = (state_q == StResp) & gnt_q;
  assign bus.resp0_rdata = gnt_q ? 32'h0 : rdata_q;
  assign bus.resp1_rdata = gnt_q ? rdata_q : 32'h0;
  assign bus.resp0_err   = ~gnt_q & err_q;
  assign bus.resp1_err   = gnt_q & err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus a randomized run
// scored against a transaction-level reference model.
module tb_dmem_arbiter;

  logic clk = 1'b0;
  logic reset_n;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  dmem_arbiter_if bus ();

  dmem_arbiter #(
    .TIMEOUT_CYCLES(15),
    .CNT_W         (4)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  // Memory model: 0 = nominal (busy for two sampled cycles after a strobe),
  // 1 = stall stuck high, 2 = stall never raised.
  int        mem_mode = 0;
  int        busy_cnt = 0;
  bit [31:0] mem_arr [4096];
  bit        written [4096];
  bit [31:0] rd_q = 32'h0;

  function automatic logic [31:0] init_word(input logic [31:0] a);
    if (a == 32'h0000_1000) return 32'hDEAD_BEEF;
    return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction

  always @(negedge clk) begin
    if (bus.mem_memwrite) begin
      mem_arr[bus.mem_addr[13:2]] = bus.mem_write_data;
      written[bus.mem_addr[13:2]] = 1'b1;
    end
    if (bus.mem_memread) begin
      rd_q = written[bus.mem_addr[13:2]] ? mem_arr[bus.mem_addr[13:2]] : init_word(bus.mem_addr);
    end
    if (bus.mem_memread || bus.mem_memwrite) busy_cnt = 3;
    else if (busy_cnt > 0) busy_cnt--;
  end

  assign bus.mem_clk_stall = (mem_mode == 1) ? 1'b1 : (mem_mode == 2) ? 1'b0 : (busy_cnt != 0);
  assign bus.mem_read_data = rd_q;

  task automatic drive_req(input int p, input logic [31:0] a, input logic [31:0] d,
                           input logic we, input logic [3:0] m);
    if (p == 0) begin
      bus.req0_valid = 1'b1; bus.req0_addr = a; bus.req0_wdata = d;
      bus.req0_we = we; bus.req0_sign_mask = m;
    end else begin
      bus.req1_valid = 1'b1; bus.req1_addr = a; bus.req1_wdata = d;
      bus.req1_we = we; bus.req1_sign_mask = m;
    end
  endtask

  task automatic clear_req(input int p);
    if (p == 0) begin
      bus.req0_valid = 1'b0; bus.req0_addr = '0; bus.req0_wdata = '0;
      bus.req0_we = 1'b0; bus.req0_sign_mask = '0;
    end else begin
      bus.req1_valid = 1'b0; bus.req1_addr = '0; bus.req1_wdata = '0;
      bus.req1_we = 1'b0; bus.req1_sign_mask = '0;
    end
  endtask

  function automatic logic port_ready(input int p);
    return (p == 0) ? bus.req0_ready : bus.req1_ready;
  endfunction

  // Move to 1 time unit after the next rising edge (drive point).
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    clear_req(0);
    clear_req(1);
    mem_mode = 0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    next_cycle();
  endtask

  // One request on one port; returns what was observed. Starts at a drive point,
  // ends at the sample point of the response cycle (or of the last cycle tried).
  task automatic do_txn(input int port, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic we, input logic [3:0] mask, input int mode_after,
                        output int wait_acc, output bit got, output int lat,
                        output logic [31:0] rdata, output logic err, output int n_rd,
                        output int n_wr, output int strobe_cyc, output logic [31:0] s_addr,
                        output logic [31:0] s_wdata, output logic [3:0] s_mask,
                        output int other);
    bit acc;
    wait_acc = 0; got = 0; lat = 0; rdata = '0; err = 1'b0; n_rd = 0; n_wr = 0;
    strobe_cyc = -1; s_addr = '0; s_wdata = '0; s_mask = '0; other = 0;
    drive_req(port, addr, wdata, we, mask);
    #1;
    acc = port_ready(port);
    while (!acc && wait_acc < 60) begin
      @(posedge clk);
      #2;
      wait_acc++;
      acc = port_ready(port);
    end
    if (!acc) begin
      clear_req(port);
      return;
    end
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) begin
        clear_req(port);
        if (mode_after >= 0) mem_mode = mode_after;
      end
      #1;
      if ((bus.mem_memread || bus.mem_memwrite) && strobe_cyc < 0) begin
        strobe_cyc = c; s_addr = bus.mem_addr; s_wdata = bus.mem_write_data;
        s_mask = bus.mem_sign_mask;
      end
      if (bus.mem_memread) n_rd++;
      if (bus.mem_memwrite) n_wr++;
      if ((port == 0) ? bus.resp1_valid : bus.resp0_valid) other++;
      if ((port == 0) ? bus.resp0_valid : bus.resp1_valid) begin
        got = 1; lat = c;
        rdata = (port == 0) ? bus.resp0_rdata : bus.resp1_rdata;
        err   = (port == 0) ? bus.resp0_err : bus.resp1_err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    clear_req(0);
    clear_req(1);
    mem_mode = 0;
    #3;
    checks++;
    if ({bus.req0_ready, bus.req1_ready, bus.resp0_valid, bus.resp1_valid} !== 4'b0) begin
      failures++;
      $display("FAIL reset_handshake: got=%b exp=0000",
               {bus.req0_ready, bus.req1_ready, bus.resp0_valid, bus.resp1_valid});
    end
    checks++;
    if ({bus.mem_memread, bus.mem_memwrite, bus.resp0_err, bus.resp1_err} !== 4'b0) begin
      failures++;
      $display("FAIL reset_strobes: got=%b exp=0000",
               {bus.mem_memread, bus.mem_memwrite, bus.resp0_err, bus.resp1_err});
    end
    checks++;
    if ({bus.mem_addr, bus.mem_write_data, bus.mem_sign_mask} !== 68'h0) begin
      failures++;
      $display("FAIL reset_mem_bus: got=%h exp=0",
               {bus.mem_addr, bus.mem_write_data, bus.mem_sign_mask});
    end
    checks++;
    if ({bus.resp0_rdata, bus.resp1_rdata} !== 64'h0) begin
      failures++;
      $display("FAIL reset_rdata: got=%h exp=0", {bus.resp0_rdata, bus.resp1_rdata});
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_read_port0();
    int w, lat, nr, nw, sc, oth;
    bit got;
    logic [31:0] rd, sa, sd;
    logic er;
    logic [3:0] sm;
    do_txn(0, 32'h1000, 32'h0, 1'b0, 4'b0111, -1, w, got, lat, rd, er, nr, nw, sc, sa, sd, sm,
           oth);
    checks++;
    if (w !== 0) begin failures++; $display("FAIL rd0_accept_c0: got=%0d exp=0", w); end
    checks++;
    if ({nr, nw, sc} !== {32'd1, 32'd0, 32'd1}) begin
      failures++;
      $display("FAIL rd0_strobe: got rd=%0d wr=%0d cyc=%0d exp rd=1 wr=0 cyc=1", nr, nw, sc);
    end
    checks++;
    if ({sa, sm} !== {32'h1000, 4'b0111}) begin
      failures++;
      $display("FAIL rd0_mem_addr_mask: got=%h/%b exp=1000/0111", sa, sm);
    end
    checks++;
    if ({got, lat} !== {1'b1, 32'd5}) begin
      failures++;
      $display("FAIL rd0_resp_c5: got valid=%0d lat=%0d exp valid=1 lat=5", got, lat);
    end
    checks++;
    if ({rd, er} !== {32'hDEAD_BEEF, 1'b0}) begin
      failures++;
      $display("FAIL rd0_rdata_err: got=%h/%0d exp=deadbeef/0", rd, er);
    end
    checks++;
    if (oth !== 0) begin failures++; $display("FAIL rd0_resp1_quiet: got=%0d exp=0", oth); end
    next_cycle();
    #1;
    checks++;
    if (bus.resp0_valid !== 1'b0) begin
      failures++;
      $display("FAIL rd0_resp_one_cycle: got=%b exp=0", bus.resp0_valid);
    end
    #1;
  endtask

  task automatic test_write_port1();
    int w, lat, nr, nw, sc, oth;
    bit got;
    logic [31:0] rd, sa, sd;
    logic er;
    logic [3:0] sm;
    do_txn(1, 32'h2000, 32'h0000_00A5, 1'b1, 4'b0010, -1, w, got, lat, rd, er, nr, nw, sc, sa,
           sd, sm, oth);
    checks++;
    if ({nr, nw, sc} !== {32'd0, 32'd1, 32'd1}) begin
      failures++;
      $display("FAIL wr1_strobe: got rd=%0d wr=%0d cyc=%0d exp rd=0 wr=1 cyc=1", nr, nw, sc);
    end
    checks++;
    if ({sa, sd, sm} !== {32'h2000, 32'hA5, 4'b0010}) begin
      failures++;
      $display("FAIL wr1_mem_bus: got=%h/%h/%b exp=2000/a5/0010", sa, sd, sm);
    end
    checks++;
    if ({got, lat, rd, er} !== {1'b1, 32'd5, 32'h0, 1'b0}) begin
      failures++;
      $display("FAIL wr1_resp: got v=%0d lat=%0d rd=%h err=%0d exp v=1 lat=5 rd=0 err=0",
               got, lat, rd, er);
    end
    checks++;
    if ({w, oth} !== 64'h0) begin
      failures++;
      $display("FAIL wr1_accept_quiet: got wait=%0d other=%0d exp 0/0", w, oth);
    end
    next_cycle();
    do_txn(0, 32'h2000, 32'h0, 1'b0, 4'b0010, -1, w, got, lat, rd, er, nr, nw, sc, sa, sd, sm,
           oth);
    checks++;
    if ({got, rd, er} !== {1'b1, 32'hA5, 1'b0}) begin
      failures++;
      $display("FAIL wr1_readback: got v=%0d rd=%h err=%0d exp v=1 rd=a5 err=0", got, rd, er);
    end
    next_cycle();
  endtask

  task automatic test_timeout();
    int w, lat, nr, nw, sc, oth;
    bit got;
    logic [31:0] rd, sa, sd;
    logic er;
    logic [3:0] sm;
    // Stall goes high from ISSUE on and never drops.
    do_txn(0, 32'h1000, 32'h0, 1'b0, 4'hF, 1, w, got, lat, rd, er, nr, nw, sc, sa, sd, sm, oth);
    checks++;
    if ({got, lat, rd, er} !== {1'b1, 32'd17, 32'h0, 1'b1}) begin
      failures++;
      $display("FAIL to_stuck: got v=%0d lat=%0d rd=%h err=%0d exp v=1 lat=17 rd=0 err=1",
               got, lat, rd, er);
    end
    next_cycle();
    mem_mode = 2;
    do_txn(1, 32'h3000, 32'h1234, 1'b1, 4'h2, -1, w, got, lat, rd, er, nr, nw, sc, sa, sd, sm,
           oth);
    checks++;
    if (w !== 0) begin failures++; $display("FAIL to_back_to_idle: got=%0d exp=0", w); end
    checks++;
    if ({got, lat, rd, er, oth} !== {1'b1, 32'd17, 32'h0, 1'b1, 32'd0}) begin
      failures++;
      $display("FAIL to_never_busy: got v=%0d lat=%0d rd=%h err=%0d oth=%0d exp 1/17/0/1/0",
               got, lat, rd, er, oth);
    end
    next_cycle();
    mem_mode = 0;
  endtask

  task automatic test_reset_mid();
    int w, lat, nr, nw, sc, oth;
    bit got;
    logic [31:0] rd, sa, sd;
    logic er;
    logic [3:0] sm;
    drive_req(0, 32'h1000, 32'h0, 1'b0, 4'hF);
    #1;
    checks++;
    if (bus.req0_ready !== 1'b1) begin
      failures++;
      $display("FAIL rm_accept: got=%b exp=1", bus.req0_ready);
    end
    next_cycle();
    clear_req(0);
    mem_mode = 1;
    next_cycle();
    next_cycle();
    reset_n = 1'b0;
    #1;
    checks++;
    if ({bus.mem_memread, bus.mem_memwrite, bus.resp0_valid, bus.resp1_valid, bus.req0_ready,
         bus.mem_addr, bus.resp0_rdata} !== 69'h0) begin
      failures++;
      $display("FAIL rm_outputs_zero: got=%h exp=0", {bus.mem_memread, bus.mem_memwrite,
               bus.resp0_valid, bus.resp1_valid, bus.req0_ready, bus.mem_addr, bus.resp0_rdata});
    end
    next_cycle();
    reset_n = 1'b1;
    drive_req(0, 32'h2000, 32'h0, 1'b0, 4'h1);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({bus.req0_ready, bus.resp0_valid} !== 2'b00) begin
        failures++;
        $display("FAIL rm_blocked_by_stall: got=%b exp=00", {bus.req0_ready, bus.resp0_valid});
      end
      next_cycle();
    end
    clear_req(0);
    mem_mode = 0;
    do_txn(0, 32'h2000, 32'h0, 1'b0, 4'h1, -1, w, got, lat, rd, er, nr, nw, sc, sa, sd, sm, oth);
    checks++;
    if ({w, got, lat, rd, er} !== {32'd0, 1'b1, 32'd5, 32'hA5, 1'b0}) begin
      failures++;
      $display("FAIL rm_recover: got w=%0d v=%0d lat=%0d rd=%h err=%0d exp 0/1/5/a5/0",
               w, got, lat, rd, er);
    end
    next_cycle();
  endtask

  task automatic test_arbitration();
    int seq[$];
    int acc_cyc[$];
    int both = 0;
    int exp_seq[4];
`ifdef DMEM_ARB_RR_EN
    exp_seq = '{0, 1, 0, 1};
`else
    exp_seq = '{0, 0, 0, 0};
`endif
    do_reset();
    drive_req(0, 32'h1000, 32'h0, 1'b0, 4'h3);
    drive_req(1, 32'h1004, 32'h0, 1'b0, 4'h3);
    #1;
    for (int c = 0; c < 100 && seq.size() < 4; c++) begin
      if (bus.req0_ready && bus.req1_ready) both++;
      else if (bus.req0_ready) begin seq.push_back(0); acc_cyc.push_back(c); end
      else if (bus.req1_ready) begin seq.push_back(1); acc_cyc.push_back(c); end
      @(posedge clk);
      #2;
    end
    clear_req(0);
    clear_req(1);
    checks++;
    if (both !== 0) begin failures++; $display("FAIL arb_one_ready: got=%0d exp=0", both); end
    checks++;
    if (seq.size() !== 4) begin
      failures++;
      $display("FAIL arb_count: got=%0d exp=4", seq.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (seq[i] !== exp_seq[i]) begin
          failures++;
          $display("FAIL arb_grant_%0d: got=%0d exp=%0d", i, seq[i], exp_seq[i]);
        end
      end
      checks++;
      if (acc_cyc[1] - acc_cyc[0] !== 6) begin
        failures++;
        $display("FAIL arb_throughput: got=%0d exp=6", acc_cyc[1] - acc_cyc[0]);
      end
    end
    repeat (8) @(posedge clk);
    #1;
  endtask

  // Randomized traffic on both ports against a transaction-level model: a transaction
  // accepted in cycle k strobes in k+1, responds in k+5, and the next grant is possible
  // from k+6. Tie-break follows the configured arbitration rule.
  logic [31:0] ref_mem [logic [31:0]];

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return init_word(a);
  endfunction

  task automatic test_random();
    bit          pend [2];
    logic [31:0] p_addr [2];
    logic [31:0] p_wdata [2];
    logic        p_we [2];
    logic [3:0]  p_mask [2];
    int          m_issue = -10, m_resp = -10, m_free = 0, m_port = 0, m_last = 1, n_acc = 0;
    int          win;
    logic        m_we = 1'b0;
    logic [31:0] m_addr = '0, m_data = '0;
    logic [3:0]  m_mask = '0;
    logic [1:0]  exp_rdy, exp_v, exp_strb;
    do_reset();
    pend[0] = 0;
    pend[1] = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && $urandom_range(0, 2) == 0) begin
          pend[p]    = 1;
          p_addr[p]  = 32'h4000 + 32'($urandom_range(0, 15)) * 4;
          p_wdata[p] = $urandom;
          p_we[p]    = 1'($urandom_range(0, 1));
          p_mask[p]  = 4'($urandom_range(0, 15));
        end
        if (pend[p]) drive_req(p, p_addr[p], p_wdata[p], p_we[p], p_mask[p]);
        else clear_req(p);
      end
      #1;
      win = -1;
      if (cyc >= m_free) begin
        if (pend[0] && pend[1]) begin
`ifdef DMEM_ARB_RR_EN
          win = (m_last == 0) ? 1 : 0;
`else
          win = 0;
`endif
        end else if (pend[0]) win = 0;
        else if (pend[1]) win = 1;
      end
      exp_rdy  = {win == 1, win == 0};
      exp_v    = {cyc == m_resp && m_port == 1, cyc == m_resp && m_port == 0};
      exp_strb = (cyc == m_issue) ? (m_we ? 2'b10 : 2'b01) : 2'b00;
      checks++;
      if ({bus.req1_ready, bus.req0_ready} !== exp_rdy) begin
        failures++;
        $display("FAIL rnd_ready c%0d: got=%b exp=%b", cyc, {bus.req1_ready, bus.req0_ready},
                 exp_rdy);
      end
      checks++;
      if ({bus.resp1_valid, bus.resp0_valid} !== exp_v) begin
        failures++;
        $display("FAIL rnd_resp_valid c%0d: got=%b exp=%b", cyc,
                 {bus.resp1_valid, bus.resp0_valid}, exp_v);
      end
      checks++;
      if ({bus.mem_memwrite, bus.mem_memread} !== exp_strb) begin
        failures++;
        $display("FAIL rnd_strobe c%0d: got=%b exp=%b", cyc,
                 {bus.mem_memwrite, bus.mem_memread}, exp_strb);
      end
      if (cyc == m_issue) begin
        checks++;
        if ({bus.mem_addr, bus.mem_sign_mask} !== {m_addr, m_mask}) begin
          failures++;
          $display("FAIL rnd_issue_bus c%0d: got=%h/%h exp=%h/%h", cyc, bus.mem_addr,
                   bus.mem_sign_mask, m_addr, m_mask);
        end
      end
      if (cyc == m_resp) begin
        checks++;
        if (((m_port == 0) ? {bus.resp0_rdata, bus.resp0_err} : {bus.resp1_rdata, bus.resp1_err})
            !== {m_data, 1'b0}) begin
          failures++;
          $display("FAIL rnd_resp_data c%0d: got=%h/%b exp=%h/0", cyc,
                   (m_port == 0) ? bus.resp0_rdata : bus.resp1_rdata,
                   (m_port == 0) ? bus.resp0_err : bus.resp1_err, m_data);
        end
      end
      if (win >= 0) begin
        m_port  = win;
        m_last  = win;
        m_we    = p_we[win];
        m_addr  = p_addr[win];
        m_mask  = p_mask[win];
        if (p_we[win]) begin
          ref_mem[p_addr[win]] = p_wdata[win];
          m_data = 32'h0;
        end else begin
          m_data = ref_read(p_addr[win]);
        end
        m_issue   = cyc + 1;
        m_resp    = cyc + 5;
        m_free    = cyc + 6;
        pend[win] = 0;
        n_acc++;
      end
      next_cycle();
    end
    clear_req(0);
    clear_req(1);
    checks++;
    if (n_acc < 20) begin failures++; $display("FAIL rnd_progress: got=%0d exp>=20", n_acc); end
    repeat (8) @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    clear_req(0);
    clear_req(1);
    test_reset();
    test_read_port0();
    test_write_port1();
    test_timeout();
    test_reset_mid();
    test_arbitration();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the single data memory port (addr / write_data / memwrite / memread / sign_mask / read_data / clk_stall).
- Port 0 is the CPU load/store unit; port 1 is an auxiliary master (debug loader or DMA).
- Accepts one request at a time, issues a single-cycle memread or memwrite strobe, and tracks the memory's clk_stall busy window.
- Returns a one-cycle response per request, with a timeout error if the memory never completes.

Parameters:
- TIMEOUT_CYCLES, 15: maximum WAIT cycles before an error response.
- CNT_W, 4: width of the wait counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock; all state on rising edge
- reset_n  in  1  asynchronous active-low reset
- req0_valid / req1_valid  in  1  request pending on port 0 / 1
- req0_ready / req1_ready  out  1  request accepted this cycle (combinational)
- req0_addr / req1_addr  in  32  byte address
- req0_wdata / req1_wdata  in  32  store data
- req0_we / req1_we  in  1  1 = write, 0 = read
- req0_sign_mask / req1_sign_mask  in  4  size/sign code, passed through unchanged
- resp0_valid / resp1_valid  out  1  one-cycle completion pulse
- resp0_rdata / resp1_rdata  out  32  load data; valid with resp_valid
- resp0_err / resp1_err  out  1  timeout flag; valid with resp_valid
- mem_addr  out  32  to memory addr
- mem_write_data  out  32  to memory write_data
- mem_memwrite  out  1  to memory memwrite
- mem_memread  out  1  to memory memread
- mem_sign_mask  out  4  to memory sign_mask
- mem_read_data  in  32  from memory read_data
- mem_clk_stall  in  1  from memory clk_stall (busy)

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE; all outputs 0; wait counter 0; seen_busy 0; last_grant=1 (port 0 wins the first tie).
- States:
  - IDLE -> ISSUE: on accept.
  - ISSUE -> WAIT: always, after 1 cycle.
  - WAIT -> RESP: on completion or timeout.
  - RESP -> IDLE: always, after 1 cycle.
- IDLE:
  - reqN_ready = (state==IDLE) & ~mem_clk_stall & grantN & reqN_valid. At most one ready per cycle.
  - On accept, addr, wdata, we, sign_mask and the granted index are latched into buffers.
  - A requester must hold its request fields stable until ready.
- ISSUE:
  - mem_addr, mem_write_data and mem_sign_mask driven from the buffers.
  - Exactly one of mem_memread (we=0) or mem_memwrite (we=1) is 1 for this single cycle.
- WAIT:
  - Strobes are 0; mem_addr and data stay driven from the buffers.
  - Counter increments each cycle.
  - seen_busy is set when mem_clk_stall=1.
  - Completion: seen_busy=1 and mem_clk_stall=0; capture mem_read_data (0 for writes), err=0.
  - Timeout: counter==TIMEOUT_CYCLES without completion; rdata=0, err=1.
  - Completion takes precedence over timeout in the same cycle.
- RESP:
  - respN_valid=1 for exactly one cycle on the granted port only; rdata and err are registered.
  - Counter and seen_busy are cleared.
- Latency with the nominal memory (stall high for 2 cycles):
  - Accept in cycle C0, ISSUE in C1, WAIT in C2..C4 (completion seen in C4), resp_valid in C5.
  - Next accept no earlier than C6. Throughput is one transaction per 6 cycles.
- Arbitration:
  - See Optional Feature.
  - A grant is decided only in IDLE. A request arriving in any other state waits, with ready=0.
- Simultaneous events:
  - Both valid in IDLE: one winner only; the loser sees ready=0 and retries.
  - A new request during RESP is not accepted until IDLE.
- Reset mid-operation:
  - Arbiter returns to IDLE immediately; no response is generated for the aborted transaction.
  - The mem_clk_stall gate on ready blocks new accepts until the memory finishes any in-flight access.
- Store to 0x2000 (LED register) is passed through like any other store.

Optional Feature:
- Macro DMEM_ARB_RR_EN.
- Defined: round-robin arbitration.
  - On a tie, the port not in last_grant wins; last_grant updates on each accept.
  - With both ports continuously requesting, grants alternate 0,1,0,1.
- Undefined: fixed priority, port 0 always wins a tie.
  - last_grant register is absent.
  - Port 1 can starve while port 0 is continuously valid.

Test Plan:
- Reset, then port 0 read of 0x1000 with memory word 0xDEADBEEF and sign_mask 0b0111 -> req0_ready in C0, mem_memread=1 only in C1, resp0_valid in C5 with rdata 0xDEADBEEF and err=0, resp1_valid stays 0.
- Port 1 write of 0x0000_00A5 to 0x2000 -> mem_memwrite=1 for exactly 1 cycle with mem_addr=0x2000, resp1_valid with err=0 and rdata=0.
- Both ports valid continuously, 4 transactions -> with DMEM_ARB_RR_EN, grants 0,1,0,1; without it, grants 0,0,0,0.
- Memory model holds mem_clk_stall=1 indefinitely -> resp_valid with err=1 and rdata=0 after 15 WAIT cycles; arbiter then returns to IDLE.
- Memory never raises mem_clk_stall -> timeout error, no false completion.
- Assert reset_n=0 during WAIT while the memory stall is still high -> all outputs 0 immediately; no ready until mem_clk_stall=0; next request completes normally.
